// File: rtl/adder_result_stage.sv
// Result stage behind the adder: a show-ahead FIFO of W+1-bit sums with a
// valid/ready output, plus a saturating running total and an accepted-sum counter.
module adder_result_stage #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W:0]       in_sum,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic             out_carry,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf,
    output logic [15:0]      op_count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0]    cnt_t;
    typedef logic [ACC_W:0] acc_ext_t;

    logic [W:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    cnt_t             count;
    logic             push, pop;
    logic [ACC_W-1:0] acc_base, acc_next;
    acc_ext_t         acc_sum;
    logic             ovf_next;

    assign full      = (count == cnt_t'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is read straight from storage; masked to zero so an empty FIFO shows 0.
    assign out_sum   = empty ? '0 : mem[rd_ptr];
    assign out_carry = out_sum[W];

    // Clear is folded in ahead of the accumulation so clear+push yields acc=in_sum.
    always_comb begin
        acc_base = clear ? '0 : acc;
        acc_sum  = {1'b0, acc_base} + acc_ext_t'(in_sum);
        acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        ovf_next = (acc_ovf && !clear) || acc_sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= in_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            op_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push) begin
                acc      <= acc_next;
                acc_ovf  <= ovf_next;
                op_count <= op_count + 1'b1;
            end else if (clear) begin
                acc      <= '0;
                acc_ovf  <= 1'b0;
                op_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench: stimulus queues expected sums, a negedge monitor checks the FIFO head.
module tb_adder_result_stage;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, clear, out_ready;
    logic [W:0]    in_sum;
    logic          in_ready, out_valid, out_carry, acc_ovf, full, empty;
    logic [W:0]    out_sum;
    logic [47:0]   acc;
    logic [15:0]   op_count;

    logic          in_valid34;
    logic [W:0]    in_sum34;
    logic          in_ready34, out_valid34, out_carry34, acc_ovf34, full34, empty34;
    logic [W:0]    out_sum34;
    logic [33:0]   acc34;
    logic [15:0]   op_count34;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W:0]    exp_q[$];

    always #5 clk = ~clk;

    adder_result_stage #(.W(W), .DEPTH(4), .ACC_W(48)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .acc(acc), .acc_ovf(acc_ovf),
        .op_count(op_count), .full(full), .empty(empty)
    );

    adder_result_stage #(.W(W), .DEPTH(4), .ACC_W(34)) dut34 (
        .clk(clk), .reset(reset), .in_valid(in_valid34), .in_ready(in_ready34),
        .in_sum(in_sum34), .clear(1'b0), .out_valid(out_valid34), .out_ready(1'b1),
        .out_sum(out_sum34), .out_carry(out_carry34), .acc(acc34), .acc_ovf(acc_ovf34),
        .op_count(op_count34), .full(full34), .empty(empty34)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of in_valid; the bench decides acceptance from its own scenario.
    task automatic push(input logic [W:0] v, input bit accept);
        in_valid = 1'b1;
        in_sum   = v;
        chk("in_ready_before_push", {63'd0, in_ready}, {63'd0, accept});
        if (accept) exp_q.push_back(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!empty && n < 20) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_empty", {63'd0, empty}, 64'd1);
        chk("drain_queue_size", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every head that is consumed must match the oldest expected sum.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale_entry: got %0h expected no valid output", out_sum);
            end else if (out_ready) begin
                chk("fifo_order", 64'(out_sum), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sum = '0; clear = 1'b0; out_ready = 1'b0;
        in_valid34 = 1'b0; in_sum34 = '0;

        // 1: reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_empty",     {63'd0, empty},     64'd1);
        chk("rst_full",      {63'd0, full},      64'd0);
        chk("rst_acc",       64'(acc),           64'd0);
        chk("rst_acc_ovf",   {63'd0, acc_ovf},   64'd0);
        chk("rst_op_count",  64'(op_count),      64'd0);
        chk("rst_out_sum",   64'(out_sum),       64'd0);

        // 2: three pushes, one-cycle latency, then in-order drain
        push(33'd2, 1'b1);
        chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_out_sum",   64'(out_sum),       64'd2);
        push(33'd11, 1'b1);
        push(33'd4, 1'b1);
        chk("t2_acc",      64'(acc),      64'd17);
        chk("t2_op_count", 64'(op_count), 64'd3);
        drain();

        // 3: fill to full, refused fifth push, push+pop while full pops only
        for (int i = 1; i <= 5; i++) push(33'(i), i <= 4);
        chk("t3_full",      {63'd0, full},     64'd1);
        chk("t3_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("t3_acc",       64'(acc),          64'd27);
        chk("t3_op_count",  64'(op_count),     64'd7);
        out_ready = 1'b1;
        push(33'd99, 1'b0);
        out_ready = 1'b0;
        chk("t3_not_full",  {63'd0, full},     64'd0);
        chk("t3_not_empty", {63'd0, empty},    64'd0);
        chk("t3_acc_hold",  64'(acc),          64'd27);
        chk("t3_op_hold",   64'(op_count),     64'd7);
        drain();

        // 4: carry-out sum
        push(33'h1_0000_0000, 1'b1);
        chk("t4_out_carry", {63'd0, out_carry}, 64'd1);
        chk("t4_out_low",   64'(out_sum[31:0]), 64'd0);
        chk("t4_acc",       64'(acc),           64'd4294967323);
        drain();

        // 5: saturation on the 34-bit accumulator
        in_sum34 = 33'h1_FFFF_FFFF;
        in_valid34 = 1'b1;
        tick(); tick();
        chk("t5_acc_pre_sat", 64'(acc34), 64'h3_FFFF_FFFE);
        chk("t5_ovf_pre_sat", {63'd0, acc_ovf34}, 64'd0);
        tick();
        chk("t5_acc_sat", 64'(acc34), 64'h3_FFFF_FFFF);
        chk("t5_ovf_sat", {63'd0, acc_ovf34}, 64'd1);
        in_sum34 = 33'd1;
        tick();
        in_valid34 = 1'b0;
        chk("t5_acc_stuck", 64'(acc34), 64'h3_FFFF_FFFF);
        chk("t5_ovf_stuck", {63'd0, acc_ovf34}, 64'd1);
        chk("t5_op_count",  64'(op_count34), 64'd4);

        // 6: clear alone, clear+push, then reset with entries queued
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_clr_acc", 64'(acc),      64'd0);
        chk("t6_clr_op",  64'(op_count), 64'd0);
        clear = 1'b1;
        push(33'd7, 1'b1);
        clear = 1'b0;
        chk("t6_cp_acc", 64'(acc),         64'd7);
        chk("t6_cp_op",  64'(op_count),    64'd1);
        chk("t6_cp_ovf", {63'd0, acc_ovf}, 64'd0);
        push(33'd8, 1'b1);
        push(33'd9, 1'b1);
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk("t6_rst_empty",     {63'd0, empty},     64'd1);
        chk("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_out_sum",   64'(out_sum),       64'd0);
        chk("t6_rst_acc",       64'(acc),           64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t6_post_rst_empty", {63'd0, empty}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
